stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Button-driven sequencing FSM for the stopwatch datapath. It converts debounced push-button levels into the stopwatch `enable`, `up` and clear controls, plus a display-freeze (lap) flag. The lap flag lets the display path hold a lap value while counting continues. It sits between the board buttons/debouncers and the stopwatch counter/display mux inside the stopwatch top level.

Parameters:
HOLD_CYCLES, 50_000_000, clk cycles btn_lr must stay high in PAUSE to trigger clear (long press); legal range >= 2

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
btn_ss  input  1  start/stop button, debounced level
btn_lr  input  1  lap/reset button, debounced level
btn_dir  input  1  direction toggle button, debounced level
at_zero  input  1  high when stopwatch digits == 0000 (used only with AUTO_STOP_EN)
enable  output  1  count enable to stopwatch
up  output  1  count direction to stopwatch (1 = up)
clear  output  1  one-cycle synchronous clear pulse to stopwatch
freeze  output  1  hold displayed value (lap)
state  output  2  FSM state: 00 IDLE, 01 RUN, 10 LAP, 11 PAUSE

Behaviour:
- Reset (synchronous, active-high, dominates everything):
  - state=IDLE, enable=0, up=1, clear=0, freeze=0.
  - Edge-detect registers are loaded with 0.
  - Hold counter = 0.
  - A reset asserted mid-run or mid-long-press aborts it; no clear pulse is emitted.
- Edge detection:
  - x_rise = btn_x & ~btn_x_q, where btn_x_q is btn_x registered.
  - A press is acted on at the clock edge where btn_x is first sampled 1.
  - Outputs reflect the new state after that edge, i.e. 1-cycle latency.
  - A held button generates exactly one rise.
- Output decode (from the state register and registered flags):
  - enable = (state==RUN || state==LAP).
  - freeze = (state==LAP).
- Transitions (ss_rise has priority over lr_rise when both occur in the same cycle):
  - IDLE: ss_rise -> RUN. lr_rise -> emit clear pulse, stay IDLE.
  - RUN: ss_rise -> PAUSE. lr_rise -> LAP.
  - LAP: ss_rise -> PAUSE (freeze drops). lr_rise -> RUN (freeze releases, display resumes live).
  - PAUSE:
    - ss_rise -> RUN.
    - While btn_lr==1, the hold counter increments, saturating at HOLD_CYCLES.
    - When it reaches HOLD_CYCLES: clear=1 for exactly one cycle, state -> IDLE, counter -> 0.
    - btn_lr==0 resets the counter to 0, so a short press has no effect.
    - If ss_rise occurs during a hold, go to RUN and zero the counter.
- Hold counter:
  - Width $clog2(HOLD_CYCLES+1).
  - Counts only in PAUSE; forced to 0 in every other state.
  - After a long-press clear, remaining high time on btn_lr in IDLE does nothing. Only a new rise pulses clear.
- Direction:
  - dir_rise toggles `up` only in IDLE or PAUSE.
  - It is ignored in RUN and LAP, so direction never changes while counting.
- clear:
  - Never asserted for more than 1 consecutive cycle.
  - Never asserted in RUN or LAP.

Optional Feature:
Macro: STOPWATCH_CTRL_AUTO_STOP_EN.
- Defined:
  - In RUN or LAP with up==0 and at_zero==1, the FSM goes to PAUSE at the next edge, and enable/freeze drop.
  - This prevents down-count wrap from 0000 to 9999.
  - Auto-stop has priority over ss_rise and lr_rise in the same cycle.
- Not defined:
  - at_zero is ignored (left unconnected internally).
  - The counter wraps per stopwatch behaviour.

Test Plan:
- Reset, then btn_ss high for 3 cycles starting at cycle 10 -> state=01, enable=1 from cycle 11 onward; one transition only (held button gives no second rise).
- RUN, pulse btn_lr -> state=10, freeze=1, enable=1; pulse btn_lr again -> state=01, freeze=0.
- PAUSE with HOLD_CYCLES=8: btn_lr high for 5 cycles -> no clear, state stays 11. btn_lr high for 8 cycles -> clear=1 for exactly 1 cycle, state=00, up unchanged.
- btn_ss and btn_lr rising in the same cycle while RUN -> state=11 (start/stop wins); btn_dir rise in RUN -> up stays 1; btn_dir rise in PAUSE -> up=0.
- reset asserted during LAP after 3 hold cycles -> next cycle state=00, enable=0, up=1, freeze=0, clear=0.
- With STOPWATCH_CTRL_AUTO_STOP_EN: up=0, RUN, at_zero=1 together with ss_rise -> state=11, enable=0 next cycle. Without the macro: same stimulus -> state=11 via ss_rise only; at_zero alone in RUN -> state stays 01.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Button sequencing FSM for the stopwatch datapath. It turns debounced
// push-button levels into the stopwatch controls:
//   - enable : count enable
//   - up     : count direction
//   - clear  : one-cycle clear pulse
//   - freeze : display hold, used for lap
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   btn_ss   in   start/stop button level (debounced)
//   btn_lr   in   lap/reset button level (debounced)
//   btn_dir  in   direction toggle button level (debounced)
//   at_zero  in   stopwatch digits are 0000 (auto-stop build only)
//   enable   out  count enable (RUN or LAP)
//   up       out  count direction, 1 = up
//   clear    out  one-cycle synchronous clear pulse
//   freeze   out  hold displayed value (LAP)
//   state    out  00 IDLE, 01 RUN, 10 LAP, 11 PAUSE
//
// Parameter:
//   HOLD_CYCLES  Number of cycles btn_lr must stay high in PAUSE before the
//                long press clears the count. Must be >= 2.
//
// Optional feature:
//   Define STOPWATCH_CTRL_AUTO_STOP_EN to stop a down-count at 0000.
//   With it, RUN or LAP with up==0 and at_zero==1 moves to PAUSE.
//   Without it, at_zero is ignored.
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lr,
  input  logic       btn_dir,
  input  logic       at_zero,
  output logic       enable,
  output logic       up,
  output logic       clear,
  output logic       freeze,
  output logic [1:0] state
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  // The long press completes on the cycle the count would reach HOLD_CYCLES.
  // As a result, the register never holds a value above HOLD_CYCLES-1.
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    LAP   = 2'b10,
    PAUSE = 2'b11
  } state_t;

  state_t          state_reg, state_next;
  logic            up_reg, up_next;
  logic            clear_reg, clear_next;
  logic [CW-1:0]   hold_cnt_reg, hold_cnt_next;
  logic            btn_ss_reg, btn_lr_reg, btn_dir_reg;

  logic ss_rise, lr_rise, dir_rise;
  logic auto_stop;

  assign ss_rise  = btn_ss  & ~btn_ss_reg;
  assign lr_rise  = btn_lr  & ~btn_lr_reg;
  assign dir_rise = btn_dir & ~btn_dir_reg;

`ifdef STOPWATCH_CTRL_AUTO_STOP_EN
  // Stop a down-count sitting at 0000 before it can wrap to 9999.
  assign auto_stop = ((state_reg == RUN) || (state_reg == LAP)) &&
                     !up_reg && at_zero;
`else
  assign auto_stop = 1'b0;
  logic unused_at_zero;
  assign unused_at_zero = at_zero;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      up_reg       <= 1'b1;
      clear_reg    <= 1'b0;
      hold_cnt_reg <= '0;
      btn_ss_reg   <= 1'b0;
      btn_lr_reg   <= 1'b0;
      btn_dir_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      up_reg       <= up_next;
      clear_reg    <= clear_next;
      hold_cnt_reg <= hold_cnt_next;
      btn_ss_reg   <= btn_ss;
      btn_lr_reg   <= btn_lr;
      btn_dir_reg  <= btn_dir;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    up_next       = up_reg;
    clear_next    = 1'b0;
    // The hold counter is only kept alive by an ongoing press in PAUSE.
    hold_cnt_next = '0;

    case (state_reg)
      IDLE: begin
        if (ss_rise) begin
          state_next = RUN;
        end else if (lr_rise) begin
          clear_next = 1'b1;
        end
        if (dir_rise) begin
          up_next = ~up_reg;
        end
      end

      RUN: begin
        if (auto_stop || ss_rise) begin
          state_next = PAUSE;
        end else if (lr_rise) begin
          state_next = LAP;
        end
      end

      LAP: begin
        if (auto_stop || ss_rise) begin
          state_next = PAUSE;
        end else if (lr_rise) begin
          state_next = RUN;
        end
      end

      PAUSE: begin
        if (dir_rise) begin
          up_next = ~up_reg;
        end
        if (ss_rise) begin
          state_next = RUN;
        end else if (btn_lr) begin
          if (hold_cnt_reg == HOLD_LAST) begin
            // Long press complete: clear the count and return to IDLE.
            clear_next = 1'b1;
            state_next = IDLE;
          end else begin
            hold_cnt_next = hold_cnt_reg + CW'(1);
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    enable = (state_reg == RUN) || (state_reg == LAP);
    freeze = (state_reg == LAP);
    up     = up_reg;
    clear  = clear_reg;
    state  = state_reg;
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for stopwatch_ctrl (HOLD_CYCLES = 8).
//
// Each stimulus cycle pushes the expected post-edge outputs into a queue.
// A monitor pops one entry after every rising edge and compares it with
// {state, enable, up, clear, freeze}.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_LAP   = 2'b10;
  localparam logic [1:0] S_PAUSE = 2'b11;

  logic       clk;
  logic       reset;
  logic       btn_ss, btn_lr, btn_dir, at_zero;
  logic       enable, up, clear, freeze;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  logic [5:0] exp_q[$];
  string      name_q[$];

  stopwatch_ctrl #(.HOLD_CYCLES(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_ss  (btn_ss),
    .btn_lr  (btn_lr),
    .btn_dir (btn_dir),
    .at_zero (at_zero),
    .enable  (enable),
    .up      (up),
    .clear   (clear),
    .freeze  (freeze),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then queue the outputs expected after the edge.
  task automatic cyc(input logic ss, input logic lr, input logic dir,
                     input logic az, input logic rst,
                     input logic [1:0] st, input logic u, input logic clr,
                     input string nm);
    logic en, frz;
    @(negedge clk);
    btn_ss  = ss;
    btn_lr  = lr;
    btn_dir = dir;
    at_zero = az;
    reset   = rst;
    en  = (st == S_RUN) || (st == S_LAP);
    frz = (st == S_LAP);
    exp_q.push_back({st, en, u, clr, frz});
    name_q.push_back(nm);
  endtask

  // Monitor: compare the DUT outputs against the queued expectation.
  initial begin
    logic [5:0] exp_v, act_v;
    string      nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        act_v = {state, enable, up, clear, freeze};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL %s: got {st,en,up,clr,frz}=%b_%b%b%b%b required %b_%b%b%b%b",
                   nm, act_v[5:4], act_v[3], act_v[2], act_v[1], act_v[0],
                   exp_v[5:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
        end else begin
          $display("ok   %s: {st,en,up,clr,frz}=%b_%b%b%b%b", nm,
                   act_v[5:4], act_v[3], act_v[2], act_v[1], act_v[0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; btn_ss = 1'b0; btn_lr = 1'b0; btn_dir = 1'b0; at_zero = 1'b0;

    // Reset state.
    cyc(0,0,0,0,1, S_IDLE, 1, 0, "reset0");
    cyc(0,0,0,0,1, S_IDLE, 1, 0, "reset1");
    for (int i = 0; i < 7; i++) cyc(0,0,0,0,0, S_IDLE, 1, 0, "idle_wait");

    // Start with a held start/stop button: exactly one transition.
    cyc(1,0,0,0,0, S_RUN, 1, 0, "ss_press_run");
    cyc(1,0,0,0,0, S_RUN, 1, 0, "ss_held1");
    cyc(1,0,0,0,0, S_RUN, 1, 0, "ss_held2");
    cyc(0,0,0,0,0, S_RUN, 1, 0, "ss_release");

    // Lap in, lap out.
    cyc(0,1,0,0,0, S_LAP, 1, 0, "lr_to_lap");
    cyc(0,0,0,0,0, S_LAP, 1, 0, "lap_hold");
    cyc(0,1,0,0,0, S_RUN, 1, 0, "lr_to_run");
    cyc(0,0,0,0,0, S_RUN, 1, 0, "run_live");

    // The direction button is ignored while running.
    cyc(0,0,1,0,0, S_RUN, 1, 0, "dir_in_run");
    cyc(0,0,0,0,0, S_RUN, 1, 0, "dir_in_run_rel");

    // Start/stop wins over lap in the same cycle.
    cyc(1,1,0,0,0, S_PAUSE, 1, 0, "ss_lr_same");
    cyc(0,0,0,0,0, S_PAUSE, 1, 0, "pause_idle");

    // The direction button toggles while paused.
    cyc(0,0,1,0,0, S_PAUSE, 0, 0, "dir_in_pause");
    cyc(0,0,0,0,0, S_PAUSE, 0, 0, "dir_rel");

    // A short press (5 cycles) has no effect.
    for (int i = 0; i < 5; i++) cyc(0,1,0,0,0, S_PAUSE, 0, 0, "short_press");
    cyc(0,0,0,0,0, S_PAUSE, 0, 0, "short_rel");

    // A long press (8 cycles) gives one clear pulse and IDLE, with up kept.
    for (int i = 0; i < 7; i++) cyc(0,1,0,0,0, S_PAUSE, 0, 0, "long_press");
    cyc(0,1,0,0,0, S_IDLE, 0, 1, "long_clear");
    cyc(0,1,0,0,0, S_IDLE, 0, 0, "long_held_idle");
    cyc(0,0,0,0,0, S_IDLE, 0, 0, "long_rel");

    // A new rise of the lap button in IDLE gives a single clear pulse.
    cyc(0,1,0,0,0, S_IDLE, 0, 1, "idle_lr_clear");
    cyc(0,1,0,0,0, S_IDLE, 0, 0, "idle_lr_held");
    cyc(0,0,0,0,0, S_IDLE, 0, 0, "idle_lr_rel");

    // Toggle direction in IDLE (0 -> 1 -> 0).
    cyc(0,0,1,0,0, S_IDLE, 1, 0, "idle_dir_up");
    cyc(0,0,0,0,0, S_IDLE, 1, 0, "idle_dir_rel");
    cyc(0,0,1,0,0, S_IDLE, 0, 0, "idle_dir_dn");
    cyc(0,0,0,0,0, S_IDLE, 0, 0, "idle_dir_rel2");

    // Reset during LAP after 3 cycles of lap held.
    cyc(1,0,0,0,0, S_RUN, 0, 0, "go_run");
    cyc(0,0,0,0,0, S_RUN, 0, 0, "go_run_rel");
    cyc(0,1,0,0,0, S_LAP, 0, 0, "lap_hold1");
    cyc(0,1,0,0,0, S_LAP, 0, 0, "lap_hold2");
    cyc(0,1,0,0,0, S_LAP, 0, 0, "lap_hold3");
    cyc(0,1,0,0,1, S_IDLE, 1, 0, "reset_in_lap");
    cyc(0,0,0,0,0, S_IDLE, 1, 0, "after_reset");

    // Long press aborted by reset: no clear pulse.
    cyc(1,0,0,0,0, S_RUN, 1, 0, "ab_run");
    cyc(0,0,0,0,0, S_RUN, 1, 0, "ab_run_rel");
    cyc(1,0,0,0,0, S_PAUSE, 1, 0, "ab_pause");
    cyc(0,0,0,0,0, S_PAUSE, 1, 0, "ab_pause_rel");
    for (int i = 0; i < 7; i++) cyc(0,1,0,0,0, S_PAUSE, 1, 0, "ab_press");
    cyc(0,1,0,0,1, S_IDLE, 1, 0, "ab_reset");
    cyc(0,0,0,0,0, S_IDLE, 1, 0, "ab_after");

    // Down-count with at_zero: with start/stop in the same cycle, then alone.
    cyc(0,0,1,0,0, S_IDLE, 0, 0, "az_dir_dn");
    cyc(0,0,0,0,0, S_IDLE, 0, 0, "az_dir_rel");
    cyc(1,0,0,0,0, S_RUN, 0, 0, "az_run");
    cyc(0,0,0,0,0, S_RUN, 0, 0, "az_run_rel");
    cyc(1,0,0,1,0, S_PAUSE, 0, 0, "az_with_ss");
    cyc(0,0,0,0,0, S_PAUSE, 0, 0, "az_with_ss_rel");
    cyc(1,0,0,0,0, S_RUN, 0, 0, "az_run2");
    cyc(0,0,0,0,0, S_RUN, 0, 0, "az_run2_rel");
`ifdef STOPWATCH_CTRL_AUTO_STOP_EN
    cyc(0,0,0,1,0, S_PAUSE, 0, 0, "az_alone");
    cyc(0,0,0,0,0, S_PAUSE, 0, 0, "az_alone_after");
`else
    cyc(0,0,0,1,0, S_RUN, 0, 0, "az_alone");
    cyc(0,0,0,0,0, S_RUN, 0, 0, "az_alone_after");
`endif

    // Let the monitor drain the last expectation.
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
